updown_dir_ctrl: RTL and testbench

UPDOWN_DIR_CTRL -- requirements
Module: updown_dir_ctrl

---
 rtl/updown_dir_ctrl_pkg.sv | 22 ++
 rtl/updown_dir_ctrl_debounce.sv | 64 ++++++
 rtl/updown_dir_ctrl.sv | 84 ++++++++
 tb/tb_updown_dir_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/updown_dir_ctrl_pkg.sv
// Shared constants for the up/down direction controller and its 3-bit counter.
//   dir_e      : FSM state encoding. UP=0 and DOWN=1, so m is the state bit itself.
//   CNT_W      : width of the controlled up/down counter.
//   BOUNCE_HI  : q value in UP that triggers a reversal in ping-pong mode.
//   BOUNCE_LO  : q value in DOWN that triggers a reversal in ping-pong mode.
//   CNT_MAX/MIN: wrap points used to generate tc.
package updown_dir_ctrl_pkg;

    localparam int CNT_W = 3;
    localparam int REV_W = 8;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    localparam logic [CNT_W-1:0] BOUNCE_HI = 3'b110;
    localparam logic [CNT_W-1:0] BOUNCE_LO = 3'b001;
    localparam logic [CNT_W-1:0] CNT_MAX   = 3'b111;
    localparam logic [CNT_W-1:0] CNT_MIN   = 3'b000;

endpackage

// File: rtl/updown_dir_ctrl_debounce.sv
// Push-button debouncer.
//   clk   : system clock
//   clr   : asynchronous active-low reset
//   btn   : raw asynchronous button, high = pressed
//   press : one-cycle pulse on each accepted released->pressed change
// btn goes through a 2-FF synchronizer; the accepted level follows the
// synchronized level only after DB_CYCLES consecutive samples that differ
// from it. The pulse is registered, so it is seen by the FSM one edge after
// the level is accepted.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        // Count samples that disagree with the accepted level; any agreeing
        // sample restarts the run, so short glitches never get accepted.
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/updown_dir_ctrl.sv
// Direction controller for a 3-bit up/down counter sharing the same clock.
//   clk       : system clock
//   clr       : asynchronous active-low reset
//   q         : current counter value (pre-edge value is used for decisions)
//   btn       : raw push-button, high = pressed
//   bounce_en : 1 = ping-pong between 0 and 7, 0 = manual toggle by button
//   m         : counter mode, 0 = up, 1 = down (registered state bit)
//   tc        : one-cycle pulse after each counter wrap
//   rev_cnt   : number of direction reversals since reset, mod 256
module updown_dir_ctrl
    import updown_dir_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CNT_W-1:0] q,
    input  logic             btn,
    input  logic             bounce_en,
    output logic             m,
    output logic             tc,
    output logic [REV_W-1:0] rev_cnt
);

    dir_e             state_q, state_d;
    logic             tc_q, tc_d;
    logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
    logic             press;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn),
        .press (press)
    );

    // Reversing one value early (at 6 / 1) means the counter, which samples
    // the old m on this edge, lands on 7 / 0 and then turns around without
    // ever wrapping. Presses are simply dropped in bounce mode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UP: begin
                if (bounce_en) begin
                    if (q == BOUNCE_HI) state_d = DOWN;
                end else if (press) begin
                    state_d = DOWN;
                end
            end
            DOWN: begin
                if (bounce_en) begin
                    if (q == BOUNCE_LO) state_d = UP;
                end else if (press) begin
                    state_d = UP;
                end
            end
            default: state_d = UP;
        endcase

        // The counter wraps on this edge exactly when it sits at its end
        // value while still moving towards it.
        tc_d = ((state_q == UP) && (q == CNT_MAX)) ||
               ((state_q == DOWN) && (q == CNT_MIN));

        rev_cnt_d = rev_cnt_q + {{(REV_W-1){1'b0}}, (state_d != state_q)};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= UP;
            tc_q      <= 1'b0;
            rev_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tc_q      <= tc_d;
            rev_cnt_q <= rev_cnt_d;
        end
    end

    assign m       = state_q;
    assign tc      = tc_q;
    assign rev_cnt = rev_cnt_q;

endmodule

// File: tb/tb_updown_dir_ctrl.sv
module tb_updown_dir_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] q;
    logic       btn = 1'b0;
    logic       bounce_en = 1'b0;
    logic       m;
    logic       tc;
    logic [7:0] rev_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    updown_dir_ctrl #(.DB_CYCLES(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .q         (q),
        .btn       (btn),
        .bounce_en (bounce_en),
        .m         (m),
        .tc        (tc),
        .rev_cnt   (rev_cnt)
    );

    always #5 clk = ~clk;

    // Environment: the 3-bit up/down counter steered by m.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) q <= 3'd0;
        else      q <= m ? q - 3'd1 : q + 3'd1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ben);
        clr = 1'b0;
        bounce_en = ben;
        btn = 1'b0;
        step(2);
        clr = 1'b1;
    endtask

    logic [2:0] exp_q [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                               3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        // Reset state
        #2;
        chk("rst_m", m, 0);
        chk("rst_tc", tc, 0);
        chk("rst_rev", rev_cnt, 0);

        // Manual mode, no press: counter wraps 7->0, one tc pulse
        do_reset(1'b0);
        step(7);
        chk("man_tc_pre", tc, 0);
        chk("man_q7", q, 7);
        step(1);
        chk("man_tc_wrap", tc, 1);
        chk("man_q0", q, 0);
        step(1);
        chk("man_tc_off", tc, 0);
        chk("man_q1", q, 1);
        chk("man_m", m, 0);
        chk("man_rev", rev_cnt, 0);

        // Bounce from reset: 0..7,6..0, no tc, two reversals
        do_reset(1'b1);
        for (int i = 0; i < 14; i++) begin
            step(1);
            chk($sformatf("bnc_q%0d", i), q, exp_q[i]);
            chk($sformatf("bnc_tc%0d", i), tc, 0);
        end
        chk("bnc_rev", rev_cnt, 2);
        step(1);
        chk("bnc_q_after", q, 1);

        // Glitch of 3 cycles ignored, then a long press toggles once at cycle 7
        do_reset(1'b0);
        btn = 1'b1;
        step(3);
        btn = 1'b0;
        step(10);
        chk("glitch_m", m, 0);
        chk("glitch_rev", rev_cnt, 0);
        btn = 1'b1;
        step(6);
        chk("press_m6", m, 0);
        step(1);
        chk("press_m7", m, 1);
        chk("press_rev", rev_cnt, 1);
        step(3);
        btn = 1'b0;
        step(10);
        chk("hold_m", m, 1);
        chk("hold_rev", rev_cnt, 1);

        // Reset mid-debounce while DOWN with btn held
        btn = 1'b1;
        step(4);
        clr = 1'b0;
        #1;
        chk("arst_m", m, 0);
        chk("arst_rev", rev_cnt, 0);
        chk("arst_tc", tc, 0);
        #4;
        clr = 1'b1;
        step(6);
        chk("rel_m6", m, 0);
        step(1);
        chk("rel_m7", m, 1);
        chk("rel_rev", rev_cnt, 1);
        btn = 1'b0;
        step(12);
        chk("rel_once", rev_cnt, 1);

        // Bounce mode: press landing while q==3 is ignored and not queued
        do_reset(1'b1);
        step(5);
        btn = 1'b1;
        step(7);
        chk("bp_q2", q, 2);
        chk("bp_m", m, 1);
        step(1);
        chk("bp_q1", q, 1);
        bounce_en = 1'b0;
        step(2);
        btn = 1'b0;
        step(10);
        chk("bp_late_m", m, 1);
        chk("bp_late_rev", rev_cnt, 1);

        // Entering bounce with UP and q==7: wrap, then reverse at next q==6
        do_reset(1'b0);
        step(7);
        chk("ent_q7", q, 7);
        bounce_en = 1'b1;
        step(1);
        chk("ent_wrap_q", q, 0);
        chk("ent_tc", tc, 1);
        step(6);
        chk("ent_m14", m, 0);
        step(1);
        chk("ent_m15", m, 1);
        chk("ent_rev", rev_cnt, 1);

        // rev_cnt wrap: bounce reversals every 7 edges from reset
        do_reset(1'b1);
        step(255 * 7);
        chk("wrap_255", rev_cnt, 255);
        step(7);
        chk("wrap_0", rev_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
